id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS-style pipeline, with integrated load-use hazard detection.
- Captures decoded control, operands and register indices from ID.
- Presents id_ex_Rs, id_ex_Rt and the resolved write address to the EX stage and the forwarding logic.
- Inserts a one-cycle bubble on load-use hazards and squashes the ID instruction on a taken-branch flush.

Parameters:
DATA_W, 32, operand / immediate / PC width
ALUOP_W, 4, ALU operation code width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
hold  in  1  global pipeline freeze (memory wait); register keeps contents
flush  in  1  taken branch/jump resolved in EX; squash the ID instruction
id_valid  in  1  ID holds a real instruction
id_pc_plus4  in  DATA_W  PC+4 of the ID instruction
id_rs_data  in  DATA_W  register-file read port A
id_rt_data  in  DATA_W  register-file read port B
id_imm  in  DATA_W  sign/zero-extended immediate
id_rs, id_rt, id_rd  in  5 each  register indices
id_uses_rs, id_uses_rt  in  1 each  instruction actually reads rs / rt
id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_ALUSrc, id_RegDst  in  1 each  decoded control
id_ALUOp  in  ALUOP_W  ALU operation
stall  out  1  freeze PC and IF/ID (load-use hazard)
id_ex_valid  out  1  EX holds a real instruction
id_ex_pc_plus4, id_ex_rs_data, id_ex_rt_data, id_ex_imm  out  DATA_W each  registered copies
id_ex_Rs, id_ex_Rt  out  5 each  registered source indices
id_ex_RegWriteAddr  out  5  id_RegDst ? id_rd : id_rt, resolved at capture
id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite, id_ex_MemToReg, id_ex_ALUSrc  out  1 each  registered control
id_ex_ALUOp  out  ALUOP_W  registered ALU operation

Behaviour:
- Reset (async, rst_n=0): every registered output 0, including id_ex_valid. The register then holds a bubble.
- stall is combinational. It is 1 iff all of the following hold:
  - hold=0, flush=0, id_valid=1, id_ex_valid=1, id_ex_MemRead=1, id_ex_Rt!=0
  - and either (id_uses_rs and id_rs==id_ex_Rt) or (id_uses_rt and id_rt==id_ex_Rt).
- Per-edge update, in priority order:
  1. hold=1: all registers keep their values; flush and hazard are ignored.
  2. flush=1: load a bubble.
  3. stall=1: load a bubble. IF/ID is frozen by the stall output, so the same ID instruction is re-evaluated next cycle, when stall is necessarily 0.
  4. Otherwise: capture all id_* inputs. id_ex_valid <= id_valid.
- Bubble definition:
  - valid, RegWrite, MemRead and MemWrite forced to 0.
  - Rs, Rt and RegWriteAddr forced to 0, so the forwarding logic sees no match.
  - Remaining data and control fields are don't-care; the implementation drives 0.
- When id_valid=0 in the normal-capture case, the captured RegWrite, MemRead and MemWrite are also forced to 0.
- Latency: 1 cycle, ID to EX. Load-use costs exactly 1 bubble.
- A write-address of 0 is passed through unchanged; suppression of $0 is handled downstream.
- Reset mid-stall: state clears immediately; stall deasserts because id_ex_valid=0.

Optional Feature:
HAZARD_STATS_EN
- Defined: adds outputs stall_count[31:0] and flush_count[31:0].
  - Each increments on a clock edge where hold=0 and stall=1 (respectively flush=1).
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 mid-run -> all outputs 0 immediately; stall=0.
- Load-use: EX holds lw $8 (id_ex_MemRead=1, id_ex_Rt=8); ID holds add with id_rs=8, id_uses_rs=1 -> stall=1 for one cycle; next EX is a bubble (valid=0, RegWrite=0, Rs=0); following edge captures the add and stall=0.
- No false hazard:
  - Same lw, but the ID instruction uses only rs=9 with id_rt=8 and id_uses_rt=0 -> stall=0.
  - lw with id_ex_Rt=0 -> stall=0.
- Flush vs stall: load-use condition present and flush=1 -> stall=0; the next edge loads a bubble.
- Hold: hold=1 for 3 cycles with a new id_* pattern -> outputs unchanged and stall=0; after hold drops, capture and RegWriteAddr are correct for RegDst=1 (rd=12) and RegDst=0 (rt=5).
- HAZARD_STATS_EN: 2 load-use events, 1 flush, and 1 stall asserted under hold -> stall_count=2, flush_count=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and flush/stall bubble insertion.
// Optional HAZARD_STATS_EN adds free-running stall/flush event counters.
module id_ex_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_pc_plus4,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic [4:0]         id_rd,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic               id_RegWrite,
    input  logic               id_MemRead,
    input  logic               id_MemWrite,
    input  logic               id_MemToReg,
    input  logic               id_ALUSrc,
    input  logic               id_RegDst,
    input  logic [ALUOP_W-1:0] id_ALUOp,
    output logic               stall,
    output logic               id_ex_valid,
    output logic [DATA_W-1:0]  id_ex_pc_plus4,
    output logic [DATA_W-1:0]  id_ex_rs_data,
    output logic [DATA_W-1:0]  id_ex_rt_data,
    output logic [DATA_W-1:0]  id_ex_imm,
    output logic [4:0]         id_ex_Rs,
    output logic [4:0]         id_ex_Rt,
    output logic [4:0]         id_ex_RegWriteAddr,
    output logic               id_ex_RegWrite,
    output logic               id_ex_MemRead,
    output logic               id_ex_MemWrite,
    output logic               id_ex_MemToReg,
    output logic               id_ex_ALUSrc,
    output logic [ALUOP_W-1:0] id_ex_ALUOp
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]        stall_count,
    output logic [31:0]        flush_count
`endif
);

    logic rs_hit;
    logic rt_hit;
    logic bubble;
    logic ctl_ok;

    assign rs_hit = id_uses_rs && (id_rs == id_ex_Rt);
    assign rt_hit = id_uses_rt && (id_rt == id_ex_Rt);

    always_comb begin
        stall = !hold && !flush && id_valid && id_ex_valid && id_ex_MemRead &&
                (id_ex_Rt != 5'd0) && (rs_hit || rt_hit);
    end

    assign bubble = flush || stall;
    // Side-effecting controls survive only for a real, non-squashed instruction.
    assign ctl_ok = id_valid && !bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_valid        <= 1'b0;
            id_ex_pc_plus4     <= '0;
            id_ex_rs_data      <= '0;
            id_ex_rt_data      <= '0;
            id_ex_imm          <= '0;
            id_ex_Rs           <= '0;
            id_ex_Rt           <= '0;
            id_ex_RegWriteAddr <= '0;
            id_ex_RegWrite     <= 1'b0;
            id_ex_MemRead      <= 1'b0;
            id_ex_MemWrite     <= 1'b0;
            id_ex_MemToReg     <= 1'b0;
            id_ex_ALUSrc       <= 1'b0;
            id_ex_ALUOp        <= '0;
        end else if (!hold) begin
            id_ex_valid        <= ctl_ok;
            id_ex_pc_plus4     <= bubble ? '0 : id_pc_plus4;
            id_ex_rs_data      <= bubble ? '0 : id_rs_data;
            id_ex_rt_data      <= bubble ? '0 : id_rt_data;
            id_ex_imm          <= bubble ? '0 : id_imm;
            id_ex_Rs           <= bubble ? 5'd0 : id_rs;
            id_ex_Rt           <= bubble ? 5'd0 : id_rt;
            id_ex_RegWriteAddr <= bubble ? 5'd0 : (id_RegDst ? id_rd : id_rt);
            id_ex_RegWrite     <= id_RegWrite && ctl_ok;
            id_ex_MemRead      <= id_MemRead && ctl_ok;
            id_ex_MemWrite     <= id_MemWrite && ctl_ok;
            id_ex_MemToReg     <= !bubble && id_MemToReg;
            id_ex_ALUSrc       <= !bubble && id_ALUSrc;
            id_ex_ALUOp        <= bubble ? '0 : id_ALUOp;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (!hold) begin
            if (stall) stall_count <= stall_count + 32'd1;
            if (flush) flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule
